// File: rtl/fx_writeback_arbiter.sv
// fx_writeback_arbiter: round-robin sharing of the two FX register-file writeback ports among numUnits producers
// ports: clock_i/reset_i (sync, active-high); reqValid_i/reqAddress_i/reqData_i per-unit requests;
//   reqReady_o combinational grant; fxReg1*/fxReg2* registered writebacks; rrPointer_o debug; grantCount_o total grants
module fx_writeback_arbiter #(
  parameter int numUnits     = 4,
  parameter int unitIdxWidth = 2,
  parameter int regWidth     = 5,
  parameter int dataWidth    = 64
) (
  input  logic                          clock_i,
  input  logic                          reset_i,
  input  logic [numUnits-1:0]           reqValid_i,
  input  logic [numUnits*regWidth-1:0]  reqAddress_i,
  input  logic [numUnits*dataWidth-1:0] reqData_i,
  output logic [numUnits-1:0]           reqReady_o,
  output logic                          fxReg1isWriteback_o,
  output logic [regWidth-1:0]           fxReg1WritebackAddress_o,
  output logic [dataWidth-1:0]          fxReg1WritebackData_o,
  output logic                          fxReg2isWriteback_o,
  output logic [regWidth-1:0]           fxReg2WritebackAddress_o,
  output logic [dataWidth-1:0]          fxReg2WritebackData_o,
  output logic [unitIdxWidth-1:0]       rrPointer_o,
  output logic [31:0]                   grantCount_o
);
  logic                    s1_v, s2_v;
  logic [unitIdxWidth-1:0] s1_idx, s2_idx, idx, nxt_ptr;
  logic [regWidth-1:0]     s1_addr;
  always_comb begin
    reqReady_o = '0;
    s1_v = 1'b0;
    s2_v = 1'b0;
    s1_idx = '0;
    s2_idx = '0;
    s1_addr = '0;
    idx = '0;
    for (int k = 0; k < numUnits; k++) begin
      idx = unitIdxWidth'((int'(rrPointer_o) + k) % numUnits);
      if (!reset_i && reqValid_i[idx]) begin
        if (!s1_v) begin
          s1_v = 1'b1;
          s1_idx = idx;
          s1_addr = reqAddress_i[int'(idx)*regWidth +: regWidth];
          reqReady_o[idx] = 1'b1;
        end else if (!s2_v && reqAddress_i[int'(idx)*regWidth +: regWidth] != s1_addr) begin
          s2_v = 1'b1;
          s2_idx = idx;
          reqReady_o[idx] = 1'b1;
        end
      end
    end
    nxt_ptr = unitIdxWidth'((int'(s2_v ? s2_idx : s1_idx) + 1) % numUnits);
  end
  always_ff @(posedge clock_i) begin
    if (reset_i) begin
      fxReg1isWriteback_o      <= 1'b0;
      fxReg1WritebackAddress_o <= '0;
      fxReg1WritebackData_o    <= '0;
      fxReg2isWriteback_o      <= 1'b0;
      fxReg2WritebackAddress_o <= '0;
      fxReg2WritebackData_o    <= '0;
      rrPointer_o              <= '0;
      grantCount_o             <= '0;
    end else begin
      fxReg1isWriteback_o <= s1_v;
      fxReg2isWriteback_o <= s2_v;
      if (s1_v) begin
        fxReg1WritebackAddress_o <= s1_addr;
        fxReg1WritebackData_o    <= reqData_i[int'(s1_idx)*dataWidth +: dataWidth];
        rrPointer_o              <= nxt_ptr;
      end
      if (s2_v) begin
        fxReg2WritebackAddress_o <= reqAddress_i[int'(s2_idx)*regWidth +: regWidth];
        fxReg2WritebackData_o    <= reqData_i[int'(s2_idx)*dataWidth +: dataWidth];
      end
      grantCount_o <= grantCount_o + 32'(s1_v) + 32'(s2_v);
    end
  end
endmodule

// File: tb/tb_fx_writeback_arbiter.sv
// tb_fx_writeback_arbiter: directed checks of grant selection, conflicts, fairness and reset
module tb_fx_writeback_arbiter;
  logic        clk = 1'b0;
  logic        rst;
  logic [3:0]  valid;
  logic [19:0] addr;
  logic [255:0] data;
  logic [3:0]  ready;
  logic        wb1, wb2;
  logic [4:0]  a1, a2;
  logic [63:0] d1, d2;
  logic [1:0]  ptr;
  logic [31:0] cnt;
  int passed = 0;
  int total = 0;
  always #5 clk = ~clk;
  fx_writeback_arbiter dut (
    .clock_i(clk), .reset_i(rst), .reqValid_i(valid), .reqAddress_i(addr), .reqData_i(data),
    .reqReady_o(ready),
    .fxReg1isWriteback_o(wb1), .fxReg1WritebackAddress_o(a1), .fxReg1WritebackData_o(d1),
    .fxReg2isWriteback_o(wb2), .fxReg2WritebackAddress_o(a2), .fxReg2WritebackData_o(d2),
    .rrPointer_o(ptr), .grantCount_o(cnt)
  );
  task automatic tick();
    @(posedge clk);
    #1;
  endtask
  task automatic set_req(input int u, input logic [4:0] a, input logic [63:0] d);
    valid[u] = 1'b1;
    addr[u*5 +: 5] = a;
    data[u*64 +: 64] = d;
  endtask
  task automatic do_reset();
    rst = 1'b1;
    valid = '0;
    tick();
    tick();
    rst = 1'b0;
  endtask
  task automatic test_reset();
    rst = 1'b1;
    valid = '0;
    addr = '0;
    data = '0;
    set_req(1, 5'd3, 64'h11);
    #1;
    total++; if (ready !== 4'b0000) $display("FAIL reset_ready got %b want 0000", ready); else passed++;
    tick();
    tick();
    total++; if ({wb1, wb2} !== 2'b00) $display("FAIL reset_wb got %b want 00", {wb1, wb2}); else passed++;
    total++; if (ptr !== 2'd0) $display("FAIL reset_ptr got %0d want 0", ptr); else passed++;
    total++; if (cnt !== 32'd0) $display("FAIL reset_cnt got %0d want 0", cnt); else passed++;
    valid = '0;
    rst = 1'b0;
    tick();
    total++; if ({wb1, wb2, ptr} !== 4'b0000) $display("FAIL idle_state got %b want 0000", {wb1, wb2, ptr}); else passed++;
    total++; if (cnt !== 32'd0) $display("FAIL idle_cnt got %0d want 0", cnt); else passed++;
  endtask
  task automatic test_single();
    do_reset();
    set_req(2, 5'd7, 64'hAB);
    #1;
    total++; if (ready !== 4'b0100) $display("FAIL single_ready got %b want 0100", ready); else passed++;
    tick();
    valid = '0;
    total++; if ({wb1, a1, d1} !== {1'b1, 5'd7, 64'hAB}) $display("FAIL single_wb1 got %b/%0d/%h want 1/7/ab", wb1, a1, d1); else passed++;
    total++; if (wb2 !== 1'b0) $display("FAIL single_wb2 got %b want 0", wb2); else passed++;
    total++; if (ptr !== 2'd3) $display("FAIL single_ptr got %0d want 3", ptr); else passed++;
    total++; if (cnt !== 32'd1) $display("FAIL single_cnt got %0d want 1", cnt); else passed++;
  endtask
  task automatic test_all_four();
    do_reset();
    for (int u = 0; u < 4; u++) set_req(u, 5'(u + 1), 64'(16 + u));
    #1;
    total++; if (ready !== 4'b0011) $display("FAIL all_readyA got %b want 0011", ready); else passed++;
    tick();
    valid[1:0] = 2'b00;
    total++; if ({wb1, a1, d1} !== {1'b1, 5'd1, 64'h10}) $display("FAIL all_A_wb1 got %b/%0d/%h want 1/1/10", wb1, a1, d1); else passed++;
    total++; if ({wb2, a2, d2} !== {1'b1, 5'd2, 64'h11}) $display("FAIL all_A_wb2 got %b/%0d/%h want 1/2/11", wb2, a2, d2); else passed++;
    total++; if (ptr !== 2'd2) $display("FAIL all_A_ptr got %0d want 2", ptr); else passed++;
    #1;
    total++; if (ready !== 4'b1100) $display("FAIL all_readyB got %b want 1100", ready); else passed++;
    tick();
    valid = '0;
    total++; if ({wb1, a1, d1} !== {1'b1, 5'd3, 64'h12}) $display("FAIL all_B_wb1 got %b/%0d/%h want 1/3/12", wb1, a1, d1); else passed++;
    total++; if ({wb2, a2, d2} !== {1'b1, 5'd4, 64'h13}) $display("FAIL all_B_wb2 got %b/%0d/%h want 1/4/13", wb2, a2, d2); else passed++;
    total++; if (ptr !== 2'd0) $display("FAIL all_B_ptr got %0d want 0", ptr); else passed++;
    total++; if (cnt !== 32'd4) $display("FAIL all_B_cnt got %0d want 4", cnt); else passed++;
    tick();
    total++; if ({wb1, wb2, a1, a2} !== {2'b00, 5'd3, 5'd4}) $display("FAIL all_hold got %b/%b/%0d/%0d want 0/0/3/4", wb1, wb2, a1, a2); else passed++;
  endtask
  task automatic test_conflict();
    do_reset();
    set_req(0, 5'd5, 64'hA0);
    set_req(1, 5'd5, 64'hA1);
    set_req(2, 5'd6, 64'hA2);
    #1;
    total++; if (ready !== 4'b0101) $display("FAIL conf_ready1 got %b want 0101", ready); else passed++;
    tick();
    valid[0] = 1'b0;
    valid[2] = 1'b0;
    total++; if ({wb1, a1, d1} !== {1'b1, 5'd5, 64'hA0}) $display("FAIL conf_wb1 got %b/%0d/%h want 1/5/a0", wb1, a1, d1); else passed++;
    total++; if ({wb2, a2, d2} !== {1'b1, 5'd6, 64'hA2}) $display("FAIL conf_wb2 got %b/%0d/%h want 1/6/a2", wb2, a2, d2); else passed++;
    total++; if (ptr !== 2'd3) $display("FAIL conf_ptr got %0d want 3", ptr); else passed++;
    #1;
    total++; if (ready !== 4'b0010) $display("FAIL conf_ready2 got %b want 0010", ready); else passed++;
    tick();
    valid = '0;
    total++; if ({wb1, a1, d1, wb2} !== {1'b1, 5'd5, 64'hA1, 1'b0}) $display("FAIL conf_retry got %b/%0d/%h/%b want 1/5/a1/0", wb1, a1, d1, wb2); else passed++;
    total++; if ({ptr, cnt} !== {2'd2, 32'd3}) $display("FAIL conf_ptrcnt got %0d/%0d want 2/3", ptr, cnt); else passed++;
  endtask
  task automatic test_fairness();
    bit seen = 0;
    do_reset();
    set_req(0, 5'd1, 64'h100);
    for (int c = 0; c < 10; c++) tick();
    total++; if ({ptr, cnt} !== {2'd1, 32'd10}) $display("FAIL fair_pre got %0d/%0d want 1/10", ptr, cnt); else passed++;
    set_req(3, 5'd2, 64'h300);
    #1;
    total++; if (ready !== 4'b1001) $display("FAIL fair_ready got %b want 1001", ready); else passed++;
    for (int c = 0; c < 4 && !seen; c++) begin
      seen = ready[3];
      tick();
    end
    valid[3] = 1'b0;
    total++; if (seen !== 1'b1) $display("FAIL fair_grant got %b want 1", seen); else passed++;
    total++; if ({a1, a2, ptr, cnt} !== {5'd2, 5'd1, 2'd1, 32'd12}) $display("FAIL fair_post got %0d/%0d/%0d/%0d want 2/1/1/12", a1, a2, ptr, cnt); else passed++;
    valid = '0;
  endtask
  task automatic test_reset_midflight();
    do_reset();
    set_req(2, 5'd3, 64'h33);
    tick();
    valid = '0;
    total++; if ({ptr, cnt} !== {2'd3, 32'd1}) $display("FAIL mid_pre got %0d/%0d want 3/1", ptr, cnt); else passed++;
    set_req(0, 5'd9, 64'h90);
    set_req(3, 5'd10, 64'hA3);
    rst = 1'b1;
    #1;
    total++; if (ready !== 4'b0000) $display("FAIL mid_ready got %b want 0000", ready); else passed++;
    tick();
    rst = 1'b0;
    total++; if ({wb1, wb2, ptr, cnt} !== {2'b00, 2'd0, 32'd0}) $display("FAIL mid_reset got %b/%b/%0d/%0d want 0/0/0/0", wb1, wb2, ptr, cnt); else passed++;
    #1;
    total++; if (ready !== 4'b1001) $display("FAIL mid_rearb got %b want 1001", ready); else passed++;
    tick();
    valid = '0;
    total++; if ({wb1, a1, wb2, a2} !== {1'b1, 5'd9, 1'b1, 5'd10}) $display("FAIL mid_wb got %b/%0d/%b/%0d want 1/9/1/10", wb1, a1, wb2, a2); else passed++;
    total++; if ({ptr, cnt} !== {2'd0, 32'd2}) $display("FAIL mid_post got %0d/%0d want 0/2", ptr, cnt); else passed++;
  endtask
  initial begin
    test_reset();
    test_single();
    test_all_four();
    test_conflict();
    test_fairness();
    test_reset_midflight();
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
